// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - bottom-up row-clear sequencer for the playfield grid.
// Optional score accumulator enabled by defining LINE_CLEAR_SCORE_EN.
module line_clear_ctrl #(
  parameter int ROWS = 22,
  parameter int COLS = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ROWS-1:0][COLS-1:0]  grid_i,
  output logic [ROWS-1:0][COLS-1:0]  grid_o,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 lines_cleared,
  output logic [15:0]                score_o
);

  localparam int PW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state, state_nx;
  logic [ROWS-1:0][COLS-1:0] grid_q, grid_nx;
  logic [PW-1:0]             ptr_q, ptr_nx;
  logic [4:0]                lines_q, lines_nx;
  logic                      row_full;

  assign row_full      = &grid_q[ptr_q];
  assign grid_o        = grid_q;
  assign lines_cleared = lines_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grid_q  <= '0;
      ptr_q   <= PW'(ROWS-1);
      lines_q <= '0;
    end else begin
      grid_q  <= grid_nx;
      ptr_q   <= ptr_nx;
      lines_q <= lines_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grid_nx  = grid_q;
    ptr_nx   = ptr_q;
    lines_nx = lines_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          grid_nx  = grid_i;
          ptr_nx   = PW'(ROWS-1);
          lines_nx = '0;
          state_nx = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (row_full) begin
          // Drop everything above ptr by one row; ptr stays to recheck the row that fell in.
          grid_nx[0] = '0;
          for (int i = 1; i < ROWS; i++) begin
            if (PW'(i) <= ptr_q) grid_nx[i] = grid_q[i-1];
          end
          lines_nx = lines_q + 5'd1;
        end else if (ptr_q != '0) begin
          ptr_nx = ptr_q - PW'(1);
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, weight;
  logic [16:0] score_sum;

  always_comb begin
    weight = 16'd0;
    case (lines_q)
      5'd0:    weight = 16'd0;
      5'd1:    weight = 16'd40;
      5'd2:    weight = 16'd100;
      5'd3:    weight = 16'd300;
      default: weight = 16'd1200;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {1'b0, weight};

  always_ff @(posedge clk) begin
    if (reset)              score_q <= '0;
    else if (state == DONE) score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  assign score_o = score_q;
`else
  assign score_o = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - randomized bench for line_clear_ctrl against a row-filter model.
// Score checks follow LINE_CLEAR_SCORE_EN when defined.
module tb_line_clear_ctrl;
  localparam int ROWS = 22;
  localparam int COLS = 10;
  typedef logic [ROWS-1:0][COLS-1:0] grid_t;

  logic        clk = 1'b0;
  logic        reset, start;
  grid_t       grid_i, grid_o;
  logic        busy, done;
  logic [4:0]  lines_cleared;
  logic [15:0] score_o;

  int n_vec = 0;
  int n_err = 0;
  int exp_score = 0;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .reset(reset), .start(start), .grid_i(grid_i), .grid_o(grid_o),
    .busy(busy), .done(done), .lines_cleared(lines_cleared), .score_o(score_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ROWS*COLS-1:0] obs, input logic [ROWS*COLS-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: keep the non-full rows in order, pack them against the bottom.
  function automatic grid_t model(input grid_t g, output int k);
    grid_t r = '0;
    int    dst = ROWS-1;
    k = 0;
    for (int s = ROWS-1; s >= 0; s--) begin
      if (g[s] == {COLS{1'b1}}) k++;
      else begin
        r[dst] = g[s];
        dst--;
      end
    end
    return r;
  endfunction

  function automatic int weight(input int k);
    int w[5] = '{0, 40, 100, 300, 1200};
    return (k >= 4) ? w[4] : w[k];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input grid_t g, input bit inject);
    grid_t exp_g;
    int    k, cyc, busy_cnt;
    exp_g = model(g, k);
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + weight(k);
    if (exp_score > 65535) exp_score = 65535;
`endif
    start  = 1'b1;
    grid_i = g;
    step();
    start    = 1'b0;
    cyc      = 1;
    busy_cnt = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      if (inject && cyc == 3) begin
        start  = 1'b1;
        grid_i = ~g;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("latency", cyc, ROWS + k + 1);
    check("busy_cycles", busy_cnt, ROWS + k);
    check("busy_in_done", busy, 1'b0);
    check("lines", lines_cleared, k);
    check("grid", grid_o, exp_g);
    check("score", score_o, exp_score);
    step();
    check("done_pulse", done, 1'b0);
    check("idle_after", busy, 1'b0);
    check("grid_hold", grid_o, exp_g);
    check("lines_hold", lines_cleared, k);
  endtask

  initial begin
    grid_t g;
    int    seen;
    reset  = 1'b1;
    start  = 1'b0;
    grid_i = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_grid", grid_o, '0);
    check("rst_lines", lines_cleared, '0);
    check("rst_score", score_o, '0);

    // Four full rows first so a scored build sees 0 -> 1200 -> 1240.
    g = '0;
    for (int r = 18; r < 22; r++) g[r] = 10'h3FF;
    run_pass(g, 1'b0);
    g = '0; g[21] = 10'h3FF; g[20] = 10'h001;
    run_pass(g, 1'b0);
    run_pass('0, 1'b0);
    g = '0; g[21] = 10'h3FF; g[19] = 10'h3FF; g[20] = 10'h200; g[18] = 10'h00F;
    run_pass(g, 1'b0);
    run_pass(g, 1'b1);
    g = '1;
    run_pass(g, 1'b0);

    // Reset in the 5th scan cycle discards the pass.
    g = '0; g[21] = 10'h3FF; g[10] = 10'h155;
    start  = 1'b1;
    grid_i = g;
    step();
    start = 1'b0;
    repeat (4) step();
    check("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_score = 0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_grid", grid_o, '0);
    check("mid_rst_lines", lines_cleared, '0);
    check("mid_rst_score", score_o, '0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (done) seen++;
      step();
    end
    check("no_done_after_rst", seen, 0);

    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < ROWS; r++) begin
        case ($urandom_range(0, 3))
          0:       g[r] = 10'h3FF;
          1:       g[r] = '0;
          default: g[r] = COLS'($urandom);
        endcase
      end
      run_pass(g, ($urandom_range(0, 3) == 0));
    end

`ifdef LINE_CLEAR_SCORE_EN
    g = '0;
    for (int r = 18; r < 22; r++) g[r] = 10'h3FF;
    repeat (56) run_pass(g, 1'b0);
    check("score_sat", score_o, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
